// File: rtl/darkbus_pkg.sv
// darkbus_pkg: shared state, request types and parameter defaults for the darkbus arbiter
package darkbus_pkg;
   localparam int DEF_NCORES = 4;
   localparam int DEF_TMO = 255;
   localparam logic [31:0] DEF_ERRDATA = 32'h0000_0000;
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } busreq_t;
endpackage

// File: rtl/darkrr_pick.sv
// darkrr_pick: rotating-priority picker, first set request at or after ptr, wrapping
module darkrr_pick
   import darkbus_pkg::*;
#(
   parameter int N = DEF_NCORES,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] idx,
   output logic         valid
);
   logic [W:0]   sum;
   logic [W-1:0] cand;
   assign valid = |req;
   // walk offsets from farthest to nearest so the nearest hit is written last
   always_comb begin
      idx = '0;
      sum = '0;
      cand = '0;
      for (int i = N - 1; i >= 0; i--) begin
         sum = {1'b0, ptr} + (W + 1)'(i);
         cand = (sum >= (W + 1)'(N)) ? W'(sum - (W + 1)'(N)) : W'(sum);
         if (req[cand]) idx = cand;
      end
   end
endmodule

// File: rtl/darkbus_arbiter.sv
// darkbus_arbiter: round-robin sharing of one memory port among NCORES cores, with watchdog
module darkbus_arbiter
   import darkbus_pkg::*;
#(
   parameter int          NCORES  = DEF_NCORES,
   parameter int          TMO     = DEF_TMO,
   parameter logic [31:0] ERRDATA = DEF_ERRDATA
) (
   input  logic                             XCLK,
   input  logic                             XRES,
   input  logic [NCORES-1:0]                REQ,
   input  logic [NCORES-1:0]                WR,
   input  logic [NCORES-1:0][31:0]          ADDR,
   input  logic [NCORES-1:0][31:0]          WDATA,
   input  logic [NCORES-1:0][3:0]           BE,
   output logic [NCORES-1:0]                ACK,
   output logic [NCORES-1:0]                ERR,
   output logic [31:0]                      RDATA,
   output logic                             MREQ,
   output logic                             MWR,
   output logic [31:0]                      MADDR,
   output logic [31:0]                      MWDATA,
   output logic [3:0]                       MBE,
   input  logic                             MACK,
   input  logic [31:0]                      MRDATA,
   output logic [$clog2(NCORES)-1:0]        GRANT,
   output logic                             BUSY
);
   localparam int GW = $clog2(NCORES);
   localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
   state_t            state_q, state_d;
   logic [GW-1:0]     ptr_q, ptr_d, grant_q, grant_d, pick_idx;
   logic              pick_valid;
   logic [NCORES-1:0] ack_q, ack_d, err_q, err_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              mreq_q, mreq_d;
   busreq_t           m_q, m_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              tmo_hit;

   darkrr_pick #(.N(NCORES)) u_pick (
      .req  (REQ),
      .ptr  (ptr_q),
      .idx  (pick_idx),
      .valid(pick_valid)
   );

   // comparing against TMO-1 keeps the counter from ever needing to hold TMO
   assign tmo_hit = (TMO != 0) && (cnt_q == CW'(TMO - 1));

   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      grant_d = grant_q;
      ack_d = '0;
      err_d = '0;
      rdata_d = rdata_q;
      mreq_d = mreq_q;
      m_d = m_q;
      cnt_d = cnt_q;
      if (state_q == IDLE && pick_valid) begin
         state_d = WAIT;
         grant_d = pick_idx;
         m_d = '{wr: WR[pick_idx], addr: ADDR[pick_idx], wdata: WDATA[pick_idx], be: BE[pick_idx]};
         mreq_d = 1'b1;
         cnt_d = '0;
      end else if (state_q == WAIT && (MACK || tmo_hit)) begin
         state_d = DONE;
         ack_d[grant_q] = 1'b1;
         err_d[grant_q] = !MACK;
         rdata_d = MACK ? MRDATA : ERRDATA;
         ptr_d = (grant_q == GW'(NCORES - 1)) ? '0 : grant_q + 1'b1;
         mreq_d = 1'b0;
      end else if (state_q == WAIT) begin
         cnt_d = cnt_q + 1'b1;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge XCLK or negedge XRES) begin
      if (!XRES) begin
         state_q <= IDLE;
         ptr_q <= '0;
         grant_q <= '0;
         ack_q <= '0;
         err_q <= '0;
         rdata_q <= '0;
         mreq_q <= 1'b0;
         m_q <= '0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         grant_q <= grant_d;
         ack_q <= ack_d;
         err_q <= err_d;
         rdata_q <= rdata_d;
         mreq_q <= mreq_d;
         m_q <= m_d;
         cnt_q <= cnt_d;
      end
   end

   assign ACK = ack_q;
   assign ERR = err_q;
   assign RDATA = rdata_q;
   assign MREQ = mreq_q;
   assign MWR = m_q.wr;
   assign MADDR = m_q.addr;
   assign MWDATA = m_q.wdata;
   assign MBE = m_q.be;
   assign GRANT = grant_q;
   assign BUSY = (state_q != IDLE);
endmodule

// File: tb/tb_darkbus_arbiter.sv
// tb_darkbus_arbiter: randomized transactions checked against a round-robin reference model
module tb_darkbus_arbiter;
   localparam int N = 4;
   localparam int TMO = 8;
   localparam logic [31:0] ERRDATA = 32'hDEAD_BEEF;

   logic XCLK = 1'b0;
   logic XRES;
   logic [3:0] REQ, WR, ACK, ERR, MBE;
   logic [3:0][31:0] ADDR, WDATA;
   logic [3:0][3:0] BE;
   logic [31:0] RDATA, MADDR, MWDATA, MRDATA;
   logic MREQ, MWR, MACK, BUSY;
   logic [1:0] GRANT;

   int vectors = 0;
   int miscompares = 0;
   int mptr = 0;

   darkbus_arbiter #(.NCORES(N), .TMO(TMO), .ERRDATA(ERRDATA)) dut (
      .XCLK(XCLK), .XRES(XRES), .REQ(REQ), .WR(WR), .ADDR(ADDR), .WDATA(WDATA), .BE(BE),
      .ACK(ACK), .ERR(ERR), .RDATA(RDATA), .MREQ(MREQ), .MWR(MWR), .MADDR(MADDR),
      .MWDATA(MWDATA), .MBE(MBE), .MACK(MACK), .MRDATA(MRDATA), .GRANT(GRANT), .BUSY(BUSY)
   );

   always #5 XCLK = ~XCLK;

   task automatic tick();
      @(posedge XCLK);
      #1;
   endtask

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < N; k++)
         if (((r >> ((p + k) % N)) & 4'd1) != 4'd0) return (p + k) % N;
      return -1;
   endfunction

   task automatic rand_fields();
      for (int c = 0; c < N; c++) begin
         WR[c] = 1'($urandom);
         ADDR[c] = $urandom;
         WDATA[c] = $urandom;
         BE[c] = 4'($urandom);
      end
   endtask

   task automatic reset_dut();
      XRES = 1'b0;
      REQ = '0;
      MACK = 1'b0;
      tick();
      XRES = 1'b1;
      mptr = 0;
   endtask

   // one full transaction from an idle arbiter; memory acks lat cycles after MREQ rises
   task automatic txn(input logic [3:0] req, input int lat, input bit mack_en,
                      input logic [31:0] mrd, input bit churn, output int who);
      int t_end;
      bit e_err;
      logic e_wr;
      logic [31:0] e_addr, e_wdata, e_rdata;
      logic [3:0] e_be;
      REQ = req;
      who = pick(req, mptr);
      e_wr = WR[who];
      e_addr = ADDR[who];
      e_wdata = WDATA[who];
      e_be = BE[who];
      e_err = !(mack_en && lat <= TMO - 1);
      t_end = e_err ? TMO - 1 : lat;
      e_rdata = e_err ? ERRDATA : mrd;
      tick();
      vectors++;
      if (MREQ !== 1'b1 || GRANT !== 2'(who) || MWR !== e_wr || MADDR !== e_addr ||
          MWDATA !== e_wdata || MBE !== e_be || BUSY !== 1'b1 || ACK !== 4'b0) begin
         miscompares++;
         $display("FAIL issue: MREQ=%b GRANT=%0d MWR=%b MADDR=%h MWDATA=%h MBE=%b BUSY=%b ACK=%b required MREQ=1 GRANT=%0d MWR=%b MADDR=%h MWDATA=%h MBE=%b BUSY=1 ACK=0000",
                  MREQ, GRANT, MWR, MADDR, MWDATA, MBE, BUSY, ACK, who, e_wr, e_addr, e_wdata, e_be);
      end
      for (int t = 0; t <= t_end; t++) begin
         MACK = mack_en && (t == lat);
         MRDATA = (t == lat) ? mrd : $urandom;
         if (churn) begin
            REQ = 4'($urandom);
            rand_fields();
         end
         tick();
         MACK = 1'b0;
         if (t < t_end) begin
            vectors++;
            if (MREQ !== 1'b1 || GRANT !== 2'(who) || MWR !== e_wr || MADDR !== e_addr ||
                MWDATA !== e_wdata || MBE !== e_be || BUSY !== 1'b1 || ACK !== 4'b0 || ERR !== 4'b0) begin
               miscompares++;
               $display("FAIL hold t=%0d: MREQ=%b GRANT=%0d MADDR=%h MWDATA=%h MBE=%b ACK=%b ERR=%b required MREQ=1 GRANT=%0d MADDR=%h MWDATA=%h MBE=%b ACK=0000 ERR=0000",
                        t, MREQ, GRANT, MADDR, MWDATA, MBE, ACK, ERR, who, e_addr, e_wdata, e_be);
            end
         end
      end
      vectors++;
      if (ACK !== 4'(1 << who) || ERR !== (e_err ? 4'(1 << who) : 4'b0) || RDATA !== e_rdata ||
          MREQ !== 1'b0 || BUSY !== 1'b1 || GRANT !== 2'(who)) begin
         miscompares++;
         $display("FAIL ack: ACK=%b ERR=%b RDATA=%h MREQ=%b BUSY=%b GRANT=%0d required ACK=%b ERR=%b RDATA=%h MREQ=0 BUSY=1 GRANT=%0d",
                  ACK, ERR, RDATA, MREQ, BUSY, GRANT, 4'(1 << who), e_err ? 4'(1 << who) : 4'b0, e_rdata, who);
      end
      REQ = '0;
      MACK = 1'($urandom);
      tick();
      MACK = 1'b0;
      vectors++;
      if (ACK !== 4'b0 || ERR !== 4'b0 || BUSY !== 1'b0 || MREQ !== 1'b0 || RDATA !== e_rdata) begin
         miscompares++;
         $display("FAIL done: ACK=%b ERR=%b BUSY=%b MREQ=%b RDATA=%h required ACK=0000 ERR=0000 BUSY=0 MREQ=0 RDATA=%h",
                  ACK, ERR, BUSY, MREQ, RDATA, e_rdata);
      end
      mptr = (who + 1) % N;
   endtask

   task automatic test_reset();
      XRES = 1'b0;
      #1;
      vectors++;
      if (ACK !== 4'b0 || ERR !== 4'b0 || RDATA !== 32'b0 || GRANT !== 2'b0 || BUSY !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_status: ACK=%b ERR=%b RDATA=%h GRANT=%0d BUSY=%b required all zero", ACK, ERR, RDATA, GRANT, BUSY);
      end
      vectors++;
      if (MREQ !== 1'b0 || MWR !== 1'b0 || MADDR !== 32'b0 || MWDATA !== 32'b0 || MBE !== 4'b0) begin
         miscompares++;
         $display("FAIL reset_mem: MREQ=%b MWR=%b MADDR=%h MWDATA=%h MBE=%b required all zero", MREQ, MWR, MADDR, MWDATA, MBE);
      end
      reset_dut();
   endtask

   task automatic test_single_read();
      int who;
      rand_fields();
      ADDR[1] = 32'h100;
      WR[1] = 1'b0;
      txn(4'b0010, 0, 1'b1, 32'hCAFE_F00D, 1'b0, who);
      vectors++;
      if (who !== 1 || RDATA !== 32'hCAFE_F00D) begin
         miscompares++;
         $display("FAIL single_read: winner=%0d RDATA=%h required winner=1 RDATA=cafef00d", who, RDATA);
      end
   endtask

   task automatic test_round_robin();
      int who;
      reset_dut();
      for (int i = 0; i < 5; i++) begin
         rand_fields();
         txn(4'b1111, 3, 1'b1, $urandom, 1'b0, who);
         vectors++;
         if (who !== i % N) begin
            miscompares++;
            $display("FAIL round_robin[%0d]: winner=%0d required %0d", i, who, i % N);
         end
      end
   endtask

   task automatic test_ptr_wrap();
      int who;
      int order[3];
      int e_order[3] = '{2, 0, 2};
      reset_dut();
      rand_fields();
      txn(4'b0100, 1, 1'b1, $urandom, 1'b0, order[0]);
      txn(4'b0101, 1, 1'b1, $urandom, 1'b0, order[1]);
      txn(4'b0101, 0, 1'b1, $urandom, 1'b0, order[2]);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (order[i] !== e_order[i]) begin
            miscompares++;
            $display("FAIL ptr_wrap[%0d]: winner=%0d required %0d", i, order[i], e_order[i]);
         end
      end
      who = 0;
   endtask

   task automatic test_write();
      int who;
      rand_fields();
      WR[3] = 1'b1;
      ADDR[3] = 32'h8000_0004;
      WDATA[3] = 32'h1234_5678;
      BE[3] = 4'b0011;
      txn(4'b1000, 5, 1'b1, 32'h0BAD_0001, 1'b1, who);
      vectors++;
      if (who !== 3) begin
         miscompares++;
         $display("FAIL write: winner=%0d required 3", who);
      end
   endtask

   task automatic test_timeout();
      int who;
      rand_fields();
      txn(4'b0100, 0, 1'b0, 32'h1111_2222, 1'b0, who);
      vectors++;
      if (RDATA !== ERRDATA) begin
         miscompares++;
         $display("FAIL timeout: RDATA=%h required %h", RDATA, ERRDATA);
      end
      txn(4'b0100, TMO - 1, 1'b1, 32'h5A5A_1234, 1'b0, who);
      vectors++;
      if (RDATA !== 32'h5A5A_1234) begin
         miscompares++;
         $display("FAIL timeout_race: RDATA=%h required 5a5a1234", RDATA);
      end
   endtask

   task automatic test_reset_mid_wait();
      int who;
      rand_fields();
      REQ = 4'b0010;
      tick();
      vectors++;
      if (MREQ !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_wait_start: MREQ=%b required 1", MREQ);
      end
      #2 XRES = 1'b0;
      REQ = '0;
      #1;
      vectors++;
      if (MREQ !== 1'b0 || ACK !== 4'b0 || GRANT !== 2'b0 || BUSY !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: MREQ=%b ACK=%b GRANT=%0d BUSY=%b required all zero", MREQ, ACK, GRANT, BUSY);
      end
      MACK = 1'b1;
      tick();
      tick();
      MACK = 1'b0;
      XRES = 1'b1;
      mptr = 0;
      tick();
      vectors++;
      if (ACK !== 4'b0 || MREQ !== 1'b0 || BUSY !== 1'b0) begin
         miscompares++;
         $display("FAIL lost_txn: ACK=%b MREQ=%b BUSY=%b required ACK=0000 MREQ=0 BUSY=0", ACK, MREQ, BUSY);
      end
      txn(4'b1000, 2, 1'b1, $urandom, 1'b0, who);
      vectors++;
      if (who !== 3) begin
         miscompares++;
         $display("FAIL post_reset: winner=%0d required 3", who);
      end
   endtask

   task automatic test_random();
      int who;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            REQ = '0;
            MACK = 1'b1;
            MRDATA = $urandom;
            tick();
            MACK = 1'b0;
            vectors++;
            if (ACK !== 4'b0 || MREQ !== 1'b0 || BUSY !== 1'b0) begin
               miscompares++;
               $display("FAIL idle_mack: ACK=%b MREQ=%b BUSY=%b required ACK=0000 MREQ=0 BUSY=0", ACK, MREQ, BUSY);
            end
         end
         rand_fields();
         txn(4'($urandom_range(1, 15)), $urandom_range(0, 10), $urandom_range(0, 3) != 0,
             $urandom, 1'b1, who);
      end
   endtask

   initial begin
      XRES = 1'b0;
      REQ = '0;
      MACK = 1'b0;
      MRDATA = '0;
      rand_fields();
      test_reset();
      test_single_read();
      test_round_robin();
      test_ptr_wrap();
      test_write();
      test_timeout();
      test_reset_mid_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/darkbus_arbiter.md
Name: darkbus_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit memory/IO port between the NCORES cores of the datapath group.
- Serves one transaction at a time: latch winner's request, drive the shared port, wait for the memory ack, return data and ack to the winner.
- Includes a watchdog so a silent slave cannot hang the group; grant and busy status are exported for the SoC DEBUG bus.

Parameters:
- NCORES, 4, number of requesting cores (2..8).
- TMO, 255, max cycles to wait for MACK before aborting; 0 disables the watchdog.
- ERRDATA, 32'h00000000, value returned on RDATA for an aborted transaction.

Ports:
- XCLK  input  1  system clock, all state on rising edge.
- XRES  input  1  reset, asynchronous, active-low.
- REQ  input  [NCORES-1:0]  per-core request, held until ACK.
- WR  input  [NCORES-1:0]  1 = write, 0 = read.
- ADDR  input  [NCORES-1:0][31:0]  per-core address.
- WDATA  input  [NCORES-1:0][31:0]  per-core write data.
- BE  input  [NCORES-1:0][3:0]  per-core byte enables.
- ACK  output  [NCORES-1:0]  one-cycle completion pulse, one-hot or zero.
- ERR  output  [NCORES-1:0]  one-cycle abort pulse, coincident with ACK.
- RDATA  output  32  shared read data, valid when any ACK is high.
- MREQ  output  1  memory request.
- MWR  output  1  memory write strobe qualifier.
- MADDR  output  32  memory address.
- MWDATA  output  32  memory write data.
- MBE  output  4  memory byte enables.
- MACK  input  1  memory completion.
- MRDATA  input  32  memory read data, sampled when MACK is high.
- GRANT  output  [$clog2(NCORES)-1:0]  index of current or last owner.
- BUSY  output  1  high in WAIT and DONE.

Behaviour:
- Reset (XRES low, async): state=IDLE, ptr=0, GRANT=0, ACK=0, ERR=0, RDATA=0, MREQ=0, MWR=0, MADDR=0, MWDATA=0, MBE=0, BUSY=0, tmo counter=0. Reset mid-transaction drops MREQ immediately; the lost transaction is never acked.
- States: IDLE, WAIT, DONE.
- IDLE:
  - If REQ != 0, the picker selects the first set bit at or after ptr, wrapping modulo NCORES.
  - Register GRANT=winner and MWR/MADDR/MWDATA/MBE from the winner; set MREQ=1, cnt=0; go to WAIT.
  - If REQ == 0, stay in IDLE.
- WAIT:
  - MREQ and all M* fields are held stable.
  - If MACK=1: ACK[GRANT]=1 and RDATA=MRDATA (also updated for writes); ptr=(GRANT+1) mod NCORES; MREQ=0; go to DONE.
  - Else if TMO != 0 and cnt == TMO-1: ACK[GRANT]=1, ERR[GRANT]=1, RDATA=ERRDATA, ptr advanced as above, MREQ=0; go to DONE.
  - Else cnt++.
  - MACK wins over timeout when both occur in the same cycle.
- DONE: ACK=0, ERR=0; go to IDLE. This one-cycle gap lets the acked core drop REQ before the next arbitration, so no double-service.
- ACK, ERR and RDATA are registered pulses, exactly one cycle wide. RDATA holds its value until the next ACK.
- Latency: REQ at cycle 0 with the arbiter idle gives MREQ at cycle 1. MACK at cycle k gives ACK at cycle k+1. Minimum is ACK at cycle 2 (MACK at cycle 1). Back-to-back throughput is one transaction per 3 cycles with zero-wait memory.
- MACK is ignored in IDLE and DONE.
- REQ changes during WAIT do not affect the owner; a requester dropping REQ mid-WAIT still receives its ACK.
- Fairness: with all REQ held high, grants rotate 0,1,2,3,0,…; no core waits more than NCORES-1 transactions.
- Counter width is $clog2(TMO+1); no wrap before the compare.

Decomposition:
- Package darkbus_pkg holds:
  - state enum {IDLE, WAIT, DONE} as a 2-bit typedef;
  - typedef struct busreq_t {wr, addr[31:0], wdata[31:0], be[3:0]};
  - localparams for default NCORES, TMO and ERRDATA.
- Sub-module darkrr_pick: combinational rotating-priority picker. Inputs: req vector and ptr. Outputs: index and valid. Verified standalone by exhaustive sweep over req × ptr.

Test Plan:
- Single read, zero-wait: REQ=4'b0010, ADDR[1]=32'h100, MACK high on the cycle after MREQ, MRDATA=32'hCAFEF00D. Required: MADDR=32'h100, MWR=0; ACK=4'b0010 at cycle 2 with RDATA=32'hCAFEF00D; GRANT=1.
- Round-robin: REQ=4'b1111 held and re-asserted after each ACK, MACK 3 cycles after MREQ. Required: ACK order 0,1,2,3,0; each ACK exactly one cycle wide; BUSY low only in IDLE cycles.
- Pointer wrap: ptr=3 after serving core 2, then REQ=4'b0101. Required: core 0 granted before core 2.
- Write pass-through: core 3 WR=1, ADDR=32'h8000_0004, WDATA=32'h12345678, BE=4'b0011. Required: M* fields equal to those values, stable across 5 wait cycles until MACK; then ACK[3].
- Timeout: TMO=8, MACK never asserted. Required: ACK[2]=ERR[2]=1 exactly 8 cycles after MREQ rose, RDATA=ERRDATA, MREQ low next cycle. Also with MACK on the same cycle as the timeout: ERR stays 0 and RDATA=MRDATA.
- Reset mid-WAIT: drive XRES low while MREQ=1. Required: MREQ, ACK, GRANT and BUSY go to 0 without waiting for a clock edge; after release, a fresh REQ=4'b1000 is granted to core 3.
